// File: rtl/axi_ar_arbiter.sv
// Read-address arbiter/decoder for the 2-master/2-slave AXI interconnect.
// Define AR_ROUND_ROBIN_EN for round-robin arbitration; otherwise M0 has fixed priority.
module axi_ar_arbiter #(
   parameter int unsigned       ID_W    = 4,
   parameter int unsigned       ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] S1_BASE = 32'h0001_0000
) (
   input  logic              clk,
   input  logic              rst,
   // master 0
   input  logic [ID_W-1:0]   i_arid_m0,
   input  logic [ADDR_W-1:0] i_araddr_m0,
   input  logic [3:0]        i_arlen_m0,
   input  logic [2:0]        i_arsize_m0,
   input  logic [1:0]        i_arburst_m0,
   input  logic              i_arvalid_m0,
   output logic              o_arready_m0,
   input  logic              i_rvalid_m0,
   input  logic              i_rready_m0,
   input  logic              i_rlast_m0,
   // master 1
   input  logic [ID_W-1:0]   i_arid_m1,
   input  logic [ADDR_W-1:0] i_araddr_m1,
   input  logic [3:0]        i_arlen_m1,
   input  logic [2:0]        i_arsize_m1,
   input  logic [1:0]        i_arburst_m1,
   input  logic              i_arvalid_m1,
   output logic              o_arready_m1,
   input  logic              i_rvalid_m1,
   input  logic              i_rready_m1,
   input  logic              i_rlast_m1,
   // slave 0
   output logic [ID_W:0]     o_arid_s0,
   output logic [ADDR_W-1:0] o_araddr_s0,
   output logic [3:0]        o_arlen_s0,
   output logic [2:0]        o_arsize_s0,
   output logic [1:0]        o_arburst_s0,
   output logic              o_arvalid_s0,
   input  logic              i_arready_s0,
   // slave 1
   output logic [ID_W:0]     o_arid_s1,
   output logic [ADDR_W-1:0] o_araddr_s1,
   output logic [3:0]        o_arlen_s1,
   output logic [2:0]        o_arsize_s1,
   output logic [1:0]        o_arburst_s1,
   output logic              o_arvalid_s1,
   input  logic              i_arready_s1,
   // to read-data router
   output logic              o_getaddr_default,
   output logic              o_master_signal
);

   typedef enum logic {StIdle, StGrant} state_t;

   state_t            r_state, w_state_d;
   logic              r_owner, w_owner_d;
   logic              r_last_grant, w_last_grant_d;
   logic [1:0]        r_busy, w_busy_d;
   logic [1:0]        w_elig, w_done;
   logic              w_winner, w_ready, w_hit_s0, w_hit_s1;
   logic [ID_W-1:0]   w_id;
   logic [ADDR_W-1:0] w_addr;
   logic [3:0]        w_len;
   logic [2:0]        w_size;
   logic [1:0]        w_burst;
   logic              w_valid;

   assign w_elig = {i_arvalid_m1 & ~r_busy[1], i_arvalid_m0 & ~r_busy[0]};
   assign w_done = {i_rvalid_m1 & i_rready_m1 & i_rlast_m1,
                    i_rvalid_m0 & i_rready_m0 & i_rlast_m0};

`ifdef AR_ROUND_ROBIN_EN
   assign w_winner = (&w_elig) ? ~r_last_grant : w_elig[1];
`else
   assign w_winner = ~w_elig[0];
`endif

   assign w_id     = r_owner ? i_arid_m1    : i_arid_m0;
   assign w_addr   = r_owner ? i_araddr_m1  : i_araddr_m0;
   assign w_len    = r_owner ? i_arlen_m1   : i_arlen_m0;
   assign w_size   = r_owner ? i_arsize_m1  : i_arsize_m0;
   assign w_burst  = r_owner ? i_arburst_m1 : i_arburst_m0;
   assign w_valid  = r_owner ? i_arvalid_m1 : i_arvalid_m0;
   assign w_hit_s0 = (w_addr[ADDR_W-1:16] == S0_BASE[ADDR_W-1:16]);
   assign w_hit_s1 = (w_addr[ADDR_W-1:16] == S1_BASE[ADDR_W-1:16]);

   always_comb begin
      w_state_d         = r_state;
      w_owner_d         = r_owner;
      w_last_grant_d    = r_last_grant;
      w_busy_d          = r_busy & ~w_done;
      w_ready           = 1'b0;
      o_arid_s0         = '0;
      o_araddr_s0       = '0;
      o_arlen_s0        = '0;
      o_arsize_s0       = '0;
      o_arburst_s0      = '0;
      o_arvalid_s0      = 1'b0;
      o_arid_s1         = '0;
      o_araddr_s1       = '0;
      o_arlen_s1        = '0;
      o_arsize_s1       = '0;
      o_arburst_s1      = '0;
      o_arvalid_s1      = 1'b0;
      o_getaddr_default = 1'b0;
      o_master_signal   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (|w_elig) begin
               w_owner_d      = w_winner;
               w_last_grant_d = w_winner;
               w_state_d      = StGrant;
            end
         end
         StGrant: begin
            o_arid_s0    = {r_owner, w_id};
            o_araddr_s0  = w_addr;
            o_arlen_s0   = w_len;
            o_arsize_s0  = w_size;
            o_arburst_s0 = w_burst;
            o_arid_s1    = {r_owner, w_id};
            o_araddr_s1  = w_addr;
            o_arlen_s1   = w_len;
            o_arsize_s1  = w_size;
            o_arburst_s1 = w_burst;
            if (w_hit_s0) begin
               o_arvalid_s0 = w_valid;
               w_ready      = i_arready_s0;
            end else if (w_hit_s1) begin
               o_arvalid_s1 = w_valid;
               w_ready      = i_arready_s1;
            end else begin
               // decode miss: the internal default slave accepts at once
               w_ready           = 1'b1;
               o_getaddr_default = 1'b1;
               o_master_signal   = r_owner;
            end
            if (w_valid && w_ready) begin
               w_busy_d[r_owner] = 1'b1;
               w_state_d         = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
      o_arready_m0 = w_ready & ~r_owner & (r_state == StGrant);
      o_arready_m1 = w_ready &  r_owner & (r_state == StGrant);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_busy       <= 2'b00;
      end else begin
         r_state      <= w_state_d;
         r_owner      <= w_owner_d;
         r_last_grant <= w_last_grant_d;
         r_busy       <= w_busy_d;
      end
   end

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Scoreboard bench for axi_ar_arbiter: directed ARs, expected slave-side transfers queued
// by the stimulus and popped by a negedge monitor.
module tb_axi_ar_arbiter;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;

   // which master wins when both are eligible and M0 was granted last
`ifdef AR_ROUND_ROBIN_EN
   localparam bit FIRST = 1'b1;
`else
   localparam bit FIRST = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  tgt;   // 0=S0, 1=S1, 2=default slave
      logic [4:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [ID_W-1:0]   m_id[2];
   logic [ADDR_W-1:0] m_addr[2];
   logic [3:0]        m_len[2];
   logic [2:0]        m_size[2];
   logic [1:0]        m_burst[2];
   logic              m_valid[2], rv[2], rr[2], rl[2];
   logic              arready_s0, arready_s1;

   logic              o_arready_m0, o_arready_m1;
   logic [ID_W:0]     o_arid_s0, o_arid_s1;
   logic [ADDR_W-1:0] o_araddr_s0, o_araddr_s1;
   logic [3:0]        o_arlen_s0, o_arlen_s1;
   logic [2:0]        o_arsize_s0, o_arsize_s1;
   logic [1:0]        o_arburst_s0, o_arburst_s1;
   logic              o_arvalid_s0, o_arvalid_s1;
   logic              o_getaddr_default, o_master_signal;

   axi_ar_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .i_arid_m0(m_id[0]), .i_araddr_m0(m_addr[0]), .i_arlen_m0(m_len[0]),
      .i_arsize_m0(m_size[0]), .i_arburst_m0(m_burst[0]), .i_arvalid_m0(m_valid[0]),
      .o_arready_m0(o_arready_m0),
      .i_rvalid_m0(rv[0]), .i_rready_m0(rr[0]), .i_rlast_m0(rl[0]),
      .i_arid_m1(m_id[1]), .i_araddr_m1(m_addr[1]), .i_arlen_m1(m_len[1]),
      .i_arsize_m1(m_size[1]), .i_arburst_m1(m_burst[1]), .i_arvalid_m1(m_valid[1]),
      .o_arready_m1(o_arready_m1),
      .i_rvalid_m1(rv[1]), .i_rready_m1(rr[1]), .i_rlast_m1(rl[1]),
      .o_arid_s0(o_arid_s0), .o_araddr_s0(o_araddr_s0), .o_arlen_s0(o_arlen_s0),
      .o_arsize_s0(o_arsize_s0), .o_arburst_s0(o_arburst_s0), .o_arvalid_s0(o_arvalid_s0),
      .i_arready_s0(arready_s0),
      .o_arid_s1(o_arid_s1), .o_araddr_s1(o_araddr_s1), .o_arlen_s1(o_arlen_s1),
      .o_arsize_s1(o_arsize_s1), .o_arburst_s1(o_arburst_s1), .o_arvalid_s1(o_arvalid_s1),
      .i_arready_s1(arready_s1),
      .o_getaddr_default(o_getaddr_default), .o_master_signal(o_master_signal)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   cnt_v1 = 0, cnt_def = 0, cnt_sv = 0;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [1:0] tgt, input logic [4:0] id, input logic [31:0] addr,
                       input logic [3:0] len);
      exp_t e;
      e.tgt = tgt; e.id = id; e.addr = addr; e.len = len;
      sb.push_back(e);
   endtask

   task automatic sb_pop(input logic [1:0] tgt, input logic [4:0] id, input logic [31:0] addr,
                         input logic [3:0] len);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_errors++;
         $display("FAIL sb_unexpected: got tgt=%0d id=%h addr=%h, required no transfer",
                  tgt, id, addr);
      end else begin
         e = sb.pop_front();
         if (e.tgt !== tgt || e.id !== id || e.addr !== addr || e.len !== len) begin
            n_errors++;
            $display("FAIL sb_transfer: got tgt=%0d id=%h addr=%h len=%h, required tgt=%0d id=%h addr=%h len=%h",
                     tgt, id, addr, len, e.tgt, e.id, e.addr, e.len);
         end
      end
   endtask

   // monitor: every accepted AR must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         if (o_arvalid_s1) cnt_v1++;
         if (o_arvalid_s0 || o_arvalid_s1) cnt_sv++;
         if (o_getaddr_default) cnt_def++;
         if (o_arvalid_s0 && arready_s0) sb_pop(2'd0, o_arid_s0, o_araddr_s0, o_arlen_s0);
         if (o_arvalid_s1 && arready_s1) sb_pop(2'd1, o_arid_s1, o_araddr_s1, o_arlen_s1);
         if (o_getaddr_default) begin
            chk("def_master_ready", o_master_signal ? o_arready_m1 : o_arready_m0, 1);
            sb_pop(2'd2, {o_master_signal, 4'h0}, o_araddr_s0, o_arlen_s0);
         end
      end
   end

   // starts and ends #1 after a rising edge; lat = cycles from request to acceptance
   task automatic issue(input int m, input logic [3:0] id, input logic [31:0] addr,
                        input logic [3:0] len, output int lat);
      int   t0, n;
      logic rdy;
      m_id[m] = id; m_addr[m] = addr; m_len[m] = len; m_valid[m] = 1'b1;
      t0 = cyc; n = 0; rdy = 1'b0;
      while (!rdy && n < 60) begin
         @(negedge clk);
         n++;
         rdy = (m == 0) ? o_arready_m0 : o_arready_m1;
      end
      n_checks++;
      if (!rdy) begin
         n_errors++;
         $display("FAIL issue_m%0d: got no ARREADY in 60 cycles, required acceptance", m);
         lat = -1;
      end else begin
         lat = cyc - t0;
      end
      @(posedge clk); #1;
      m_valid[m] = 1'b0;
   endtask

   task automatic complete(input int m, output int t);
      rv[m] = 1'b1; rr[m] = 1'b1; rl[m] = 1'b1; t = cyc;
      @(posedge clk); #1;
      rv[m] = 1'b0; rr[m] = 1'b0; rl[m] = 1'b0;
   endtask

   task automatic wait_valid(input int y, input string name);
      int   n;
      logic v;
      n = 0; v = 1'b0;
      while (!v && n < 20) begin
         @(negedge clk);
         n++;
         v = (y == 0) ? o_arvalid_s0 : o_arvalid_s1;
      end
      chk(name, v, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1);
   end

   initial begin
      int lat, l0, l1, t, tc, ts;
      for (int i = 0; i < 2; i++) begin
         m_id[i] = '0; m_addr[i] = '0; m_len[i] = '0; m_size[i] = 3'd2; m_burst[i] = 2'b01;
         m_valid[i] = 1'b0; rv[i] = 1'b0; rr[i] = 1'b0; rl[i] = 1'b0;
      end
      arready_s0 = 1'b1; arready_s1 = 1'b1;

      // reset: outputs idle even with a request pending
      m_valid[0] = 1'b1; m_addr[0] = 32'h40;
      repeat (2) @(posedge clk); #1;
      chk("rst_arvalid_s0", o_arvalid_s0, 0);
      chk("rst_arvalid_s1", o_arvalid_s1, 0);
      chk("rst_arready_m0", o_arready_m0, 0);
      chk("rst_arready_m1", o_arready_m1, 0);
      chk("rst_getaddr_default", o_getaddr_default, 0);
      chk("rst_master_signal", o_master_signal, 0);
      chk("rst_arid_s0", o_arid_s0, 0);
      chk("rst_araddr_s1", o_araddr_s1, 0);
      m_valid[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: M0 to S0, one-cycle latency
      push(2'd0, 5'h03, 32'h0000_0040, 4'h2);
      issue(0, 4'h3, 32'h0000_0040, 4'h2, lat);
      chk("t1_latency", lat, 1);

      // 5: M0 busy; reissue only granted two cycles after its RLAST
      push(2'd0, 5'h01, 32'h0000_0080, 4'h0);
      ts = cyc;
      fork
         issue(0, 4'h1, 32'h0000_0080, 4'h0, lat);
         begin
            repeat (4) @(posedge clk); #1;
            complete(0, tc);
         end
      join
      chk("t5_grant_after_rlast", ts + lat - tc, 2);

      // 2: M1 to S1 with slave stalling 3 cycles
      arready_s1 = 1'b0;
      cnt_v1 = 0;
      push(2'd1, 5'h12, 32'h0001_0100, 4'h3);
      fork
         issue(1, 4'h2, 32'h0001_0100, 4'h3, lat);
         begin
            wait_valid(1, "t2_arvalid_s1_seen");
            @(negedge clk);
            @(negedge clk);
            @(posedge clk); #1;
            arready_s1 = 1'b1;
         end
      join
      chk("t2_valid_hold", cnt_v1, 4);
      chk("t2_latency", lat, 4);
      complete(0, t);
      complete(1, t);

      // 3: decode misses and window edges
      cnt_def = 0; cnt_sv = 0;
      push(2'd2, 5'h00, 32'h0004_0000, 4'h1);
      issue(0, 4'h7, 32'h0004_0000, 4'h1, lat);
      chk("t3_def_latency", lat, 1);
      chk("t3_def_pulse", cnt_def, 1);
      chk("t3_no_slave_valid", cnt_sv, 0);
      complete(0, t);
      push(2'd0, 5'h19, 32'h0000_FFFC, 4'h0);
      issue(1, 4'h9, 32'h0000_FFFC, 4'h0, lat);
      complete(1, t);
      push(2'd1, 5'h0A, 32'h0001_FFF0, 4'h0);
      issue(0, 4'hA, 32'h0001_FFF0, 4'h0, lat);
      complete(0, t);
      push(2'd2, 5'h10, 32'h0002_0000, 4'h0);
      issue(1, 4'h5, 32'h0002_0000, 4'h0, lat);
      complete(1, t);

      // 4: contention after a solo M0 grant
      push(2'd0, 5'h01, 32'h0000_1000, 4'h0);
      issue(0, 4'h1, 32'h0000_1000, 4'h0, lat);
      complete(0, t);
      for (int r = 0; r < 3; r++) begin
         if (FIRST == 1'b0) begin
            push(2'd0, {1'b0, 4'(r)}, 32'h0000_2000 + 32'(r * 16), 4'h1);
            push(2'd1, {1'b1, 4'(r + 8)}, 32'h0001_2000 + 32'(r * 16), 4'h2);
         end else begin
            push(2'd1, {1'b1, 4'(r + 8)}, 32'h0001_2000 + 32'(r * 16), 4'h2);
            push(2'd0, {1'b0, 4'(r)}, 32'h0000_2000 + 32'(r * 16), 4'h1);
         end
         fork
            issue(0, 4'(r), 32'h0000_2000 + 32'(r * 16), 4'h1, l0);
            issue(1, 4'(r + 8), 32'h0001_2000 + 32'(r * 16), 4'h2, l1);
         join
         chk("t4_winner_latency", (FIRST == 1'b0) ? l0 : l1, 1);
         chk("t4_loser_latency", (FIRST == 1'b0) ? l1 : l0, 3);
         complete(0, t);
         complete(1, t);
      end

      // 6: reset during a stalled grant, with M0 left busy
      push(2'd0, 5'h04, 32'h0000_0300, 4'h0);
      issue(0, 4'h4, 32'h0000_0300, 4'h0, lat);
      arready_s0 = 1'b0;
      m_id[1] = 4'h6; m_addr[1] = 32'h0000_0200; m_len[1] = 4'h0; m_valid[1] = 1'b1;
      wait_valid(0, "t6_arvalid_s0_seen");
      #2 rst = 1'b0;
      #1;
      chk("t6_arvalid_s0_async", o_arvalid_s0, 0);
      chk("t6_arready_m1_async", o_arready_m1, 0);
      m_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      arready_s0 = 1'b1;
      @(posedge clk); #1;
      push(2'd0, 5'h05, 32'h0000_0400, 4'h0);
      issue(0, 4'h5, 32'h0000_0400, 4'h0, lat);
      chk("t6_busy_cleared", lat, 1);
      complete(0, t);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
